programmable_clock_divider: RTL and testbench
=============================================

// Module: programmable_clock_divider
// PURPOSE
//  NUM_CH-channel runtime-programmable clock/tick generator driven from the master clock.
//  Per channel: period and high time set over a write port, glitch-free update at period boundaries,
//  per-channel enable, global phase sync. Feeds display refresh, UART baud, debouncer sampling, etc.
// PARAMETERS
//  MasterFrequency  100000000  master clock frequency in Hz; used only for reset defaults
//  frequency        100        reset-default output frequency in Hz for every channel
//  bitsNumber       20         counter/period/high width W; MasterFrequency/frequency must fit in W bits
//  NUM_CH           4          number of independent channels, 1..16
// PORTS
//  InputCLK    in   1          master clock, all logic on rising edge
//  Reset       in   1          synchronous, active-high reset
//  Enable      in   NUM_CH     per-channel run enable
//  SyncAll     in   1          one-cycle strobe: restart all enabled channels together
//  WrEn        in   1          write strobe for channel configuration
//  WrCh        in   clog2(NUM_CH)  channel addressed by the write; out-of-range writes are ignored
//  WrPeriod    in   W          new period P, in InputCLK cycles
//  WrHigh      in   W          new high time H, in InputCLK cycles
//  OutputCLK   out  NUM_CH     registered divided clocks
//  Tick        out  NUM_CH     one-cycle pulse at the first cycle of each period
//  UpdPending  out  NUM_CH     1 while a written config waits for its next boundary
// BEHAVIOUR
//  Reset: all cnt=0, state IDLE, OutputCLK=0, Tick=0, UpdPending=0.
//   Shadow and active config: P0=MasterFrequency/frequency, H0=P0/2.
//  Per-channel states: IDLE, RUN. All outputs are registered.
//   In IDLE: OutputCLK=0, Tick=0, cnt=0.
//  IDLE->RUN: on an edge with Enable[c]=1. That edge is a boundary.
//  RUN->IDLE: on the first edge with Enable[c]=0. No completion of the current period.
//  Boundary, at one edge:
//   - active config <= shadow
//   - cnt <= 0
//   - Tick <= 1
//   - OutputCLK <= (0 < H_active_new)
//   - UpdPending <= 0
//  RUN, no boundary: cnt <= cnt+1, Tick <= 0, OutputCLK <= (cnt+1 < H_active).
//   A boundary occurs when cnt == P_active-1.
//  Resulting waveform: high for the first H cycles of each P-cycle period, then low.
//   Period is exactly P cycles. Tick coincides with the rising edge of OutputCLK.
//  Clamps, using active values:
//   - P<2: channel is held as IDLE while enabled; no Tick. The shadow is still applied when P>=2 is written.
//   - H=0: OutputCLK constant 0, Tick still pulses.
//   - H>=P: OutputCLK constant 1.
//  Write: WrEn loads shadow[WrCh] and sets UpdPending.
//   A write on the same edge as a boundary takes effect at that boundary, and UpdPending stays 0.
//   In IDLE, a write sets only the shadow; it is applied on enable.
//  SyncAll: forces a boundary on every RUN channel and every channel entering RUN that edge.
//   Priority: Reset > Enable low > SyncAll > natural wrap.
//  Arithmetic: cnt is W bits; compares are unsigned. cnt never exceeds P_active-1, so no wrap-around.
//  Reset mid-period: returns to reset state next edge. Reset overrides WrEn and SyncAll.
// STRUCTURE
//  Package clk_div_pkg:
//   - W and channel-index width helpers
//   - DEFAULT_PERIOD = MasterFrequency/frequency
//   - DEFAULT_HIGH = DEFAULT_PERIOD/2
//   - state encoding localparams IDLE=1'b0, RUN=1'b1
//  Sub-module divider_channel, instantiated NUM_CH times via generate. It holds cnt, state,
//   shadow/active config, and its outputs. The top decodes WrCh into per-channel write strobes
//   and fans out SyncAll.
// TESTING
//  1 Reset, Enable[0]=1, P=10,H=5: OutputCLK[0] 5 high/5 low repeating.
//    Tick[0] on cycles 0,10,20. The first Tick comes one edge after the Enable sample.
//  2 Running P=10,H=5; write P=4,H=1 at cnt=3: current period finishes as 10/5.
//    Then 1 high/3 low. UpdPending high for exactly 7 cycles.
//  3 Write coincident with the cnt=P-1 edge: new config applies at that boundary.
//    UpdPending never asserts.
//  4 Channels 0,1 with P=7,H=3 and P=5,H=2, offset start; pulse SyncAll.
//    Both Tick the next cycle together, then keep their periods. A disabled channel 2 stays 0.
//  5 Clamps: H=0 -> OutputCLK stuck 0 with Tick every P. H=P -> stuck 1. P=1 -> no Tick, output 0.
//    Then writing P=2,H=1 gives a toggle every cycle.
//  6 Reset asserted mid-period and while WrEn=1: next cycle all outputs 0.
//    Config back to P0/H0 (1000000/500000 at default params). WrCh=NUM_CH write ignored.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and reset-default helpers for the programmable clock divider.
// Module parameters cannot reach into a package, so the defaults are also offered as functions.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chState_e;

    localparam int DEFAULT_MASTER_FREQ = 100000000;
    localparam int DEFAULT_FREQ        = 100;
    localparam int DEFAULT_W           = 20;
    localparam int DEFAULT_PERIOD      = DEFAULT_MASTER_FREQ / DEFAULT_FREQ;
    localparam int DEFAULT_HIGH        = DEFAULT_PERIOD / 2;

    function automatic int chIdxWidth(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction

    function automatic int defaultPeriod(input int masterFreq, input int freq);
        return masterFreq / freq;
    endfunction

    function automatic int defaultHigh(input int masterFreq, input int freq);
        return defaultPeriod(masterFreq, freq) / 2;
    endfunction

endpackage

// File: rtl/divider_channel.sv
// One divider channel: shadow/active period and high time, cycle counter and registered outputs.
// New settings only reach the active pair at a period boundary, so the output never glitches.
module divider_channel
    import clk_div_pkg::*;
#(
    parameter int             W            = 20,
    parameter logic [W-1:0]   RESET_PERIOD = W'(20),
    parameter logic [W-1:0]   RESET_HIGH   = W'(10)
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         enable_i,
    input  logic         sync_i,
    input  logic         wrEn_i,
    input  logic [W-1:0] wrPeriod_i,
    input  logic [W-1:0] wrHigh_i,
    output logic         outClk_o,
    output logic         tick_o,
    output logic         updPending_o
);

    chState_e     state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] actPeriod_q, actPeriod_d;
    logic [W-1:0] actHigh_q, actHigh_d;
    logic [W-1:0] shPeriod_q, shPeriod_d;
    logic [W-1:0] shHigh_q, shHigh_d;
    logic         outClk_q, outClk_d;
    logic         tick_q, tick_d;
    logic         pend_q, pend_d;
    logic         boundary;
    logic         launchOk;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            actPeriod_q <= RESET_PERIOD;
            actHigh_q   <= RESET_HIGH;
            shPeriod_q  <= RESET_PERIOD;
            shHigh_q    <= RESET_HIGH;
            outClk_q    <= 1'b0;
            tick_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            actPeriod_q <= actPeriod_d;
            actHigh_q   <= actHigh_d;
            shPeriod_q  <= shPeriod_d;
            shHigh_q    <= shHigh_d;
            outClk_q    <= outClk_d;
            tick_q      <= tick_d;
            pend_q      <= pend_d;
        end
    end

    // A write on this edge is visible to a boundary on the same edge; an idle enabled channel retries every edge.
    always_comb begin
        shPeriod_d  = wrEn_i ? wrPeriod_i : shPeriod_q;
        shHigh_d    = wrEn_i ? wrHigh_i : shHigh_q;
        boundary    = enable_i && ((state_q == IDLE) || sync_i || (cnt_q == actPeriod_q - W'(1)));
        launchOk    = (shPeriod_d >= W'(2));
        state_d     = state_q;
        cnt_d       = cnt_q;
        actPeriod_d = actPeriod_q;
        actHigh_d   = actHigh_q;
        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (boundary) begin
            actPeriod_d = shPeriod_d;
            actHigh_d   = shHigh_d;
            cnt_d       = '0;
            state_d     = launchOk ? RUN : IDLE;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_comb begin
        outClk_d = 1'b0;
        tick_d   = 1'b0;
        pend_d   = pend_q;
        if (!enable_i) begin
            pend_d = pend_q | (wrEn_i && (state_q == RUN));
        end else if (boundary) begin
            pend_d = 1'b0;
            if (launchOk) begin
                tick_d   = 1'b1;
                outClk_d = (shHigh_d != '0);
            end
        end else begin
            pend_d   = pend_q | wrEn_i;
            outClk_d = (cnt_d < actHigh_q);
        end
    end

    assign outClk_o     = outClk_q;
    assign tick_o       = tick_q;
    assign updPending_o = pend_q;

endmodule

// File: rtl/programmable_clock_divider.sv
// Multi-channel programmable clock/tick generator: decodes the config write port per channel
// and fans the global sync strobe out to every divider channel.
module programmable_clock_divider
    import clk_div_pkg::*;
#(
    parameter int MasterFrequency = DEFAULT_MASTER_FREQ,
    parameter int frequency       = DEFAULT_FREQ,
    parameter int bitsNumber      = DEFAULT_W,
    parameter int NUM_CH          = 4
) (
    input  logic                          InputCLK,
    input  logic                          Reset,
    input  logic [NUM_CH-1:0]             Enable,
    input  logic                          SyncAll,
    input  logic                          WrEn,
    input  logic [chIdxWidth(NUM_CH)-1:0] WrCh,
    input  logic [bitsNumber-1:0]         WrPeriod,
    input  logic [bitsNumber-1:0]         WrHigh,
    output logic [NUM_CH-1:0]             OutputCLK,
    output logic [NUM_CH-1:0]             Tick,
    output logic [NUM_CH-1:0]             UpdPending
);

    localparam logic [bitsNumber-1:0] P0 = bitsNumber'(defaultPeriod(MasterFrequency, frequency));
    localparam logic [bitsNumber-1:0] H0 = bitsNumber'(defaultHigh(MasterFrequency, frequency));

    logic [NUM_CH-1:0] chWrEn;

    // Channel indices at or above NUM_CH match no strobe, so such writes vanish.
    always_comb begin
        chWrEn = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            chWrEn[c] = WrEn && (int'(WrCh) == c);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : gChannel
        divider_channel #(
            .W            (bitsNumber),
            .RESET_PERIOD (P0),
            .RESET_HIGH   (H0)
        ) uChannel (
            .clk_i        (InputCLK),
            .reset_i      (Reset),
            .enable_i     (Enable[c]),
            .sync_i       (SyncAll),
            .wrEn_i       (chWrEn[c]),
            .wrPeriod_i   (WrPeriod),
            .wrHigh_i     (WrHigh),
            .outClk_o     (OutputCLK[c]),
            .tick_o       (Tick[c]),
            .updPending_o (UpdPending[c])
        );
    end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Bench for programmable_clock_divider: directed scenarios with literal waveforms plus randomized
// traffic compared every cycle against a per-channel position/period model.
module tb_programmable_clock_divider;

    localparam int MF     = 2000;
    localparam int FR     = 100;
    localparam int W      = 8;
    localparam int NCH    = 3;
    localparam int P0     = MF / FR;
    localparam int H0     = P0 / 2;

    logic           InputCLK = 1'b0;
    logic           Reset = 1'b1;
    logic [NCH-1:0] Enable = '0;
    logic           SyncAll = 1'b0;
    logic           WrEn = 1'b0;
    logic [1:0]     WrCh = '0;
    logic [W-1:0]   WrPeriod = '0;
    logic [W-1:0]   WrHigh = '0;
    logic [NCH-1:0] OutputCLK;
    logic [NCH-1:0] Tick;
    logic [NCH-1:0] UpdPending;

    int checkCount = 0;
    int passCount  = 0;

    programmable_clock_divider #(
        .MasterFrequency (MF),
        .frequency       (FR),
        .bitsNumber      (W),
        .NUM_CH          (NCH)
    ) dut (
        .InputCLK   (InputCLK),
        .Reset      (Reset),
        .Enable     (Enable),
        .SyncAll    (SyncAll),
        .WrEn       (WrEn),
        .WrCh       (WrCh),
        .WrPeriod   (WrPeriod),
        .WrHigh     (WrHigh),
        .OutputCLK  (OutputCLK),
        .Tick       (Tick),
        .UpdPending (UpdPending)
    );

    always #5 InputCLK = ~InputCLK;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    endtask

    // Drive one edge worth of inputs, then return after that edge's outputs have settled.
    task automatic applyStimulus(input logic rst, input logic [NCH-1:0] en, input logic sync,
                                 input logic wr, input logic [1:0] ch, input int p, input int h);
        Reset    = rst;
        Enable   = en;
        SyncAll  = sync;
        WrEn     = wr;
        WrCh     = ch;
        WrPeriod = W'(p);
        WrHigh   = W'(h);
        @(negedge InputCLK);
    endtask

    task automatic recordRun(input int n, input logic wrFirst, input int p, input int h,
                             output logic [63:0] tv, output logic [63:0] ov, output logic [63:0] pv);
        tv = '0;
        ov = '0;
        pv = '0;
        for (int j = 0; j < n; j++) begin
            applyStimulus(1'b0, 3'b001, 1'b0, wrFirst && (j == 0), 2'd0, p, h);
            tv[j] = Tick[0];
            ov[j] = OutputCLK[0];
            pv[j] = UpdPending[0];
        end
    endtask

    // Reference model: each channel is a position within a P-cycle period; output is pos < H.
    int   mRun[NCH], mPos[NCH], mP[NCH], mH[NCH], mSP[NCH], mSH[NCH];
    logic mOut[NCH], mTick[NCH], mPend[NCH];
    logic modelValid = 1'b0;

    always @(posedge InputCLK) begin
        logic [NCH-1:0] eo, et, ep;
        for (int c = 0; c < NCH; c++) begin
            int  nsP, nsH;
            bit  wr, wasRun;
            wr     = WrEn && (int'(WrCh) == c);
            nsP    = wr ? int'(WrPeriod) : mSP[c];
            nsH    = wr ? int'(WrHigh) : mSH[c];
            wasRun = (mRun[c] != 0);
            if (Reset) begin
                mRun[c] = 0; mPos[c] = 0; mP[c] = P0; mH[c] = H0; mSP[c] = P0; mSH[c] = H0;
                mOut[c] = 0; mTick[c] = 0; mPend[c] = 0;
            end else begin
                if (!Enable[c]) begin
                    mRun[c] = 0; mPos[c] = 0; mOut[c] = 0; mTick[c] = 0;
                    if (wr && wasRun) mPend[c] = 1;
                end else if (!wasRun || SyncAll || mPos[c] == mP[c] - 1) begin
                    mP[c] = nsP; mH[c] = nsH; mPend[c] = 0; mPos[c] = 0;
                    if (nsP >= 2) begin
                        mRun[c] = 1; mTick[c] = 1; mOut[c] = (nsH > 0);
                    end else begin
                        mRun[c] = 0; mTick[c] = 0; mOut[c] = 0;
                    end
                end else begin
                    mPos[c] = mPos[c] + 1;
                    mTick[c] = 0;
                    mOut[c] = (mPos[c] < mH[c]);
                    if (wr) mPend[c] = 1;
                end
                mSP[c] = nsP;
                mSH[c] = nsH;
            end
            eo[c] = mOut[c];
            et[c] = mTick[c];
            ep[c] = mPend[c];
        end
        if (Reset) modelValid = 1'b1;
        #1;
        if (modelValid) begin
            checkOutput("model OutputCLK", 64'(OutputCLK), 64'(eo));
            checkOutput("model Tick", 64'(Tick), 64'(et));
            checkOutput("model UpdPending", 64'(UpdPending), 64'(ep));
        end
    end

    initial begin
        logic [63:0] tv, ov, pv, t1v, c2v;
        @(negedge InputCLK);
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 0, 0);
        checkOutput("reset Tick", 64'(Tick), 64'h0);
        checkOutput("reset OutputCLK", 64'(OutputCLK), 64'h0);
        checkOutput("reset UpdPending", 64'(UpdPending), 64'h0);

        // P=10/H=5, write P=4/H=1 mid-period, then a write landing exactly on a boundary.
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 10, 5);
        tv = '0; ov = '0; pv = '0;
        for (int j = 0; j < 64; j++) begin
            applyStimulus(1'b0, 3'b001, 1'b0, (j == 33) || (j == 52), 2'd0,
                          (j == 33) ? 4 : 6, (j == 33) ? 1 : 2);
            tv[j] = Tick[0];
            ov[j] = OutputCLK[0];
            pv[j] = UpdPending[0];
        end
        checkOutput("basic/update Tick train", tv, 64'h0411_1100_4010_0401);
        checkOutput("basic/update OutputCLK wave", ov, 64'h0C31_1107_C1F0_7C1F);
        checkOutput("UpdPending window", pv, 64'h0000_00FE_0000_0000);

        // Offset-started channels 0 and 1 realigned by SyncAll; channel 2 stays disabled.
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 0, 0);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 7, 3);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 5, 2);
        repeat (3) applyStimulus(1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 0, 0);
        repeat (4) applyStimulus(1'b0, 3'b011, 1'b0, 1'b0, 2'd0, 0, 0);
        tv = '0; t1v = '0; c2v = '0;
        for (int j = 0; j < 15; j++) begin
            applyStimulus(1'b0, 3'b011, j == 0, 1'b0, 2'd0, 0, 0);
            tv[j]  = Tick[0];
            t1v[j] = Tick[1];
            c2v[j] = Tick[2] | OutputCLK[2];
        end
        checkOutput("sync ch0 Tick", tv, 64'h4081);
        checkOutput("sync ch1 Tick", t1v, 64'h0421);
        checkOutput("sync ch2 idle", c2v, 64'h0);

        // Clamps: H=0, H=P, P=1, then P=2/H=1 written while enabled.
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 0, 0);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 4, 0);
        recordRun(8, 1'b0, 0, 0, tv, ov, pv);
        checkOutput("H=0 Tick", tv, 64'h11);
        checkOutput("H=0 OutputCLK", ov, 64'h0);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 4, 4);
        recordRun(8, 1'b0, 0, 0, tv, ov, pv);
        checkOutput("H=P Tick", tv, 64'h11);
        checkOutput("H=P OutputCLK", ov, 64'hFF);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1, 1);
        recordRun(4, 1'b0, 0, 0, tv, ov, pv);
        checkOutput("P=1 Tick", tv, 64'h0);
        checkOutput("P=1 OutputCLK", ov, 64'h0);
        recordRun(6, 1'b1, 2, 1, tv, ov, pv);
        checkOutput("P=2 Tick", tv, 64'h15);
        checkOutput("P=2 OutputCLK", ov, 64'h15);

        // Reset mid-period with a write pending, then an out-of-range write, then defaults.
        recordRun(6, 1'b1, 4, 2, tv, ov, pv);
        applyStimulus(1'b1, 3'b001, 1'b1, 1'b1, 2'd0, 3, 1);
        checkOutput("midreset Tick", 64'(Tick), 64'h0);
        checkOutput("midreset OutputCLK", 64'(OutputCLK), 64'h0);
        checkOutput("midreset UpdPending", 64'(UpdPending), 64'h0);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 2'd3, 4, 1);
        recordRun(40, 1'b0, 0, 0, tv, ov, pv);
        checkOutput("default Tick", tv, 64'h0000_0000_0010_0001);
        checkOutput("default OutputCLK", ov, 64'h0000_0000_3FF0_03FF);
        checkOutput("default UpdPending", pv, 64'h0);

        // Randomized traffic; the per-cycle model compare does the checking.
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic [NCH-1:0] en;
            en = Enable;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
            end
            applyStimulus($urandom_range(0, 199) == 0, en, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
                          int'($urandom_range(0, 12)), int'($urandom_range(0, 13)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
